// File: rtl/dram_request_queue.sv
// dram_request_queue
// Buffers block read/write requests from one cache and drives a single DRAM
// controller port: one request pulse per transaction, head entry held on the
// address/we/data lines until acknowledge, read data returned over a
// valid/ready response channel.
// Optional build macro: DRAM_REQ_TIMEOUT_EN adds a WAIT watchdog that reissues
// the head request after TIMEOUT_CYCLES cycles without acknowledge and sets a
// sticky timeout_error flag.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

module dram_request_queue #(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [`DRAM_ADDRESS_SIZE-1:0] req_address,
    input  logic                          req_we,
    input  logic [`DRAM_WORD_SIZE-1:0]    req_write_data [`DRAM_BLOCK_SIZE],
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [`DRAM_WORD_SIZE-1:0]    rsp_data [`DRAM_BLOCK_SIZE],
    output logic                          wr_done,
    output logic                          dram_request,
    output logic [`DRAM_ADDRESS_SIZE-1:0] dram_address,
    output logic                          dram_we,
    output logic [`DRAM_WORD_SIZE-1:0]    dram_write_data [`DRAM_BLOCK_SIZE],
    input  logic [`DRAM_WORD_SIZE-1:0]    dram_read_data [`DRAM_BLOCK_SIZE],
    input  logic                          dram_acknowledge,
    output logic                          busy,
    output logic                          timeout_error
);

    localparam int AW    = `DRAM_ADDRESS_SIZE;
    localparam int WW    = `DRAM_WORD_SIZE;
    localparam int BW    = `DRAM_BLOCK_SIZE;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject nonsensical configurations at elaboration.
    if (DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dram_request_queue: DEPTH and TIMEOUT_CYCLES must both be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [AW-1:0]    addr_mem_q [DEPTH];
    logic [AW-1:0]    addr_mem_d [DEPTH];
    logic [DEPTH-1:0] we_mem_q, we_mem_d;
    logic [WW-1:0]    data_mem_q [DEPTH][BW];
    logic [WW-1:0]    data_mem_d [DEPTH][BW];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;

    // Response path
    logic [WW-1:0]    rsp_data_q [BW];
    logic [WW-1:0]    rsp_data_d [BW];
    logic             wr_done_q, wr_done_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic timeout_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign push       = req_valid && ready_q;
    assign pop        = (state_q == S_WAIT) && dram_acknowledge;
    assign req_ready  = ready_q;
    assign wr_done    = wr_done_q;
    assign rsp_data   = rsp_data_q;

`ifdef DRAM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_error_q, timeout_error_d;

    assign timeout_hit = (state_q == S_WAIT) && !dram_acknowledge &&
                         (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: count unacknowledged WAIT cycles, restart on every reissue.
    always_comb begin
        wait_cnt_d      = '0;
        timeout_error_d = timeout_error_q;
        if (timeout_hit) begin
            wait_cnt_d      = '0;
            timeout_error_d = 1'b1;
        end else if (state_q == S_WAIT && !dram_acknowledge) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Watchdog registers; the error flag only clears through reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q      <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign timeout_error = timeout_error_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_error = 1'b0;
`endif

    // FIFO next state: write at the tail on push, advance the head on pop.
    always_comb begin
        addr_mem_d = addr_mem_q;
        we_mem_d   = we_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = req_address;
            we_mem_d[wr_ptr_q]   = req_we;
            for (int b = 0; b < BW; b++) begin
                data_mem_d[wr_ptr_q][b] = req_write_data[b];
            end
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    // FIFO registers; ready is registered so it has no path from pop or rsp_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                for (int b = 0; b < BW; b++) begin
                    data_mem_q[i][b] <= '0;
                end
            end
            we_mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            addr_mem_q <= addr_mem_d;
            we_mem_q   <= we_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
        end
    end

    // DRAM-side lines mirror the FIFO head, zero when the queue is empty.
    always_comb begin
        dram_address = '0;
        dram_we      = 1'b0;
        for (int b = 0; b < BW; b++) begin
            dram_write_data[b] = '0;
        end
        if (!fifo_empty) begin
            dram_address = addr_mem_q[rd_ptr_q];
            dram_we      = we_mem_q[rd_ptr_q];
            for (int b = 0; b < BW; b++) begin
                dram_write_data[b] = data_mem_q[rd_ptr_q][b];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; acknowledge only matters while waiting on the controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dram_acknowledge) begin
                    state_d = dram_we ? S_IDLE : S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_ISSUE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        dram_request = (state_q == S_ISSUE);
        rsp_valid    = (state_q == S_RESP);
        busy         = (state_q != S_IDLE) || !fifo_empty;
    end

    // Capture read data and flag write completion on acknowledge.
    always_comb begin
        rsp_data_d = rsp_data_q;
        wr_done_d  = pop && dram_we;
        if (pop && !dram_we) begin
            rsp_data_d = dram_read_data;
        end
    end

    // Response registers; rsp_data stays put until the next read completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < BW; b++) begin
                rsp_data_q[b] <= '0;
            end
            wr_done_q <= 1'b0;
        end else begin
            rsp_data_q <= rsp_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

endmodule

// File: tb/tb_dram_request_queue.sv
// tb_dram_request_queue
// Directed bench for dram_request_queue: read, write, full queue, response
// backpressure, reset during WAIT and (with DRAM_REQ_TIMEOUT_EN) reissue after
// timeout. Expected transactions live in a scoreboard queue filled as
// requests are driven and drained as the DUT completes them.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

module tb_dram_request_queue;

    localparam int AW    = `DRAM_ADDRESS_SIZE;
    localparam int WW    = `DRAM_WORD_SIZE;
    localparam int BW    = `DRAM_BLOCK_SIZE;
    localparam int BLK_W = WW * BW;
    localparam int CHK_W = (BLK_W > AW) ? BLK_W : AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [AW-1:0] reqAddress = '0;
    logic          reqWe = 1'b0;
    logic [WW-1:0] reqWriteData [BW];
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [WW-1:0] rspData [BW];
    logic          wrDone;
    logic          dramRequest;
    logic [AW-1:0] dramAddress;
    logic          dramWe;
    logic [WW-1:0] dramWriteData [BW];
    logic [WW-1:0] dramReadData [BW];
    logic          dramAcknowledge = 1'b0;
    logic          busy;
    logic          timeoutError;

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [BLK_W-1:0] wdata;
        logic [BLK_W-1:0] rdata;
    } exp_t;

    exp_t          expQ[$];
    logic [AW-1:0] issuedAddr[$];
    int            numAsserts = 0;
    int            numFails   = 0;
    int            reqPulses  = 0;
    int            savedPulses;

    dram_request_queue #(
        .DEPTH          (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (reqValid),
        .req_ready        (reqReady),
        .req_address      (reqAddress),
        .req_we           (reqWe),
        .req_write_data   (reqWriteData),
        .rsp_valid        (rspValid),
        .rsp_ready        (rspReady),
        .rsp_data         (rspData),
        .wr_done          (wrDone),
        .dram_request     (dramRequest),
        .dram_address     (dramAddress),
        .dram_we          (dramWe),
        .dram_write_data  (dramWriteData),
        .dram_read_data   (dramReadData),
        .dram_acknowledge (dramAcknowledge),
        .busy             (busy),
        .timeout_error    (timeoutError)
    );

    always #5 clock = ~clock;

    // Record every request pulse the controller would see.
    always @(posedge clock) begin
        if (reset && dramRequest) begin
            reqPulses++;
            issuedAddr.push_back(dramAddress);
        end
    end

    // Hard stop in case the flow wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BLK_W-1:0] mkBlock(input logic [WW-1:0] base);
        logic [BLK_W-1:0] p;
        for (int i = 0; i < BW; i++) begin
            p[i*WW +: WW] = base + WW'(i);
        end
        return p;
    endfunction

    function automatic logic [BLK_W-1:0] packBlock(input logic [WW-1:0] b [BW]);
        logic [BLK_W-1:0] p;
        for (int i = 0; i < BW; i++) begin
            p[i*WW +: WW] = b[i];
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [CHK_W-1:0] observed,
                               input logic [CHK_W-1:0] expected);
        numAsserts++;
        assert (observed === expected)
        else begin
            numFails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input logic we, input logic [AW-1:0] addr,
                            input logic [BLK_W-1:0] wdata);
        reqValid   = 1'b1;
        reqWe      = we;
        reqAddress = addr;
        for (int i = 0; i < BW; i++) begin
            reqWriteData[i] = wdata[i*WW +: WW];
        end
    endtask

    // Push one request (waiting for ready) and record what it should produce.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [WW-1:0] wbase, input logic [WW-1:0] rbase);
        exp_t e;
        e.we    = we;
        e.addr  = addr;
        e.wdata = we ? mkBlock(wbase) : '0;
        e.rdata = we ? '0 : mkBlock(rbase);
        expQ.push_back(e);
        driveReq(we, addr, e.wdata);
        for (int n = 0; n < 20 && !reqReady; n++) begin
            tick();
        end
        checkOutput("push accepted", CHK_W'(reqReady), CHK_W'(1));
        tick();
        reqValid = 1'b0;
    endtask

    task automatic waitRequest(input string tag);
        for (int n = 0; n < 30 && !dramRequest; n++) begin
            tick();
        end
        checkOutput({tag, " request pulse"}, CHK_W'(dramRequest), CHK_W'(1));
    endtask

    // Called in the ISSUE cycle: hold off ack for 'delay' cycles, then acknowledge.
    task automatic ackHead(input int delay);
        exp_t e;
        checkOutput("scoreboard has head", CHK_W'(expQ.size() != 0), CHK_W'(1));
        if (expQ.size() != 0) begin
            e = expQ[0];
            for (int n = 0; n < delay; n++) begin
                tick();
                checkOutput("single pulse", CHK_W'(dramRequest), CHK_W'(0));
                checkOutput("head address", CHK_W'(dramAddress), CHK_W'(e.addr));
                checkOutput("head we", CHK_W'(dramWe), CHK_W'(e.we));
                checkOutput("head wdata", CHK_W'(packBlock(dramWriteData)), CHK_W'(e.wdata));
            end
            dramAcknowledge = 1'b1;
            for (int i = 0; i < BW; i++) begin
                dramReadData[i] = e.rdata[i*WW +: WW];
            end
            tick();
            dramAcknowledge = 1'b0;
            for (int i = 0; i < BW; i++) begin
                dramReadData[i] = '0;
            end
        end
    endtask

    // Called the cycle after ack: pop the scoreboard and check the completion.
    task automatic collectResponse(input int hold, input bit ackNoise);
        exp_t e;
        checkOutput("scoreboard has entry", CHK_W'(expQ.size() != 0), CHK_W'(1));
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            if (e.we) begin
                checkOutput("wr_done pulse", CHK_W'(wrDone), CHK_W'(1));
                checkOutput("no rsp on write", CHK_W'(rspValid), CHK_W'(0));
                tick();
                checkOutput("wr_done one cycle", CHK_W'(wrDone), CHK_W'(0));
                checkOutput("no rsp after write", CHK_W'(rspValid), CHK_W'(0));
            end else begin
                checkOutput("rsp_valid", CHK_W'(rspValid), CHK_W'(1));
                checkOutput("rsp_data", CHK_W'(packBlock(rspData)), CHK_W'(e.rdata));
                checkOutput("no wr_done on read", CHK_W'(wrDone), CHK_W'(0));
                if (ackNoise) begin
                    dramAcknowledge = 1'b1;
                    for (int i = 0; i < BW; i++) begin
                        dramReadData[i] = '1;
                    end
                end
                for (int n = 0; n < hold; n++) begin
                    tick();
                    checkOutput("rsp_valid held", CHK_W'(rspValid), CHK_W'(1));
                    checkOutput("rsp_data stable", CHK_W'(packBlock(rspData)), CHK_W'(e.rdata));
                    checkOutput("no issue during RESP", CHK_W'(dramRequest), CHK_W'(0));
                end
                dramAcknowledge = 1'b0;
                for (int i = 0; i < BW; i++) begin
                    dramReadData[i] = '0;
                end
                rspReady = 1'b1;
                tick();
                rspReady = 1'b0;
                checkOutput("rsp_valid dropped", CHK_W'(rspValid), CHK_W'(0));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < BW; i++) begin
            reqWriteData[i] = '0;
            dramReadData[i] = '0;
        end

        // Reset state
        tick();
        tick();
        checkOutput("reset req_ready", CHK_W'(reqReady), CHK_W'(0));
        checkOutput("reset busy", CHK_W'(busy), CHK_W'(0));
        checkOutput("reset dram_request", CHK_W'(dramRequest), CHK_W'(0));
        checkOutput("reset rsp_valid", CHK_W'(rspValid), CHK_W'(0));
        checkOutput("reset timeout_error", CHK_W'(timeoutError), CHK_W'(0));
        reset = 1'b1;
        tick();
        checkOutput("ready after release", CHK_W'(reqReady), CHK_W'(1));

        // 1: single read, ack 4 cycles after request, minimum issue latency
        $display("[TB] read");
        applyStimulus(1'b0, AW'('h40), '0, WW'(1));
        checkOutput("no request at N+1", CHK_W'(dramRequest), CHK_W'(0));
        tick();
        checkOutput("request at N+2", CHK_W'(dramRequest), CHK_W'(1));
        waitRequest("read");
        ackHead(4);
        collectResponse(0, 1'b0);
        checkOutput("read idle busy", CHK_W'(busy), CHK_W'(0));
        checkOutput("read one pulse", CHK_W'(reqPulses), CHK_W'(1));

        // 2: single write with data held until ack
        $display("[TB] write");
        applyStimulus(1'b1, AW'('h80), WW'('hA), '0);
        waitRequest("write");
        checkOutput("write dram_we", CHK_W'(dramWe), CHK_W'(1));
        ackHead(3);
        collectResponse(0, 1'b0);
        checkOutput("write idle busy", CHK_W'(busy), CHK_W'(0));

        // 3: fill the queue, third request waits for the first ack
        $display("[TB] full");
        issuedAddr.delete();
        applyStimulus(1'b0, AW'('h100), '0, WW'('h10));
        applyStimulus(1'b1, AW'('h140), WW'('h20), '0);
        checkOutput("full req_ready", CHK_W'(reqReady), CHK_W'(0));
        begin
            exp_t e3;
            e3.we    = 1'b0;
            e3.addr  = AW'('h180);
            e3.wdata = '0;
            e3.rdata = mkBlock(WW'('h30));
            expQ.push_back(e3);
            driveReq(1'b0, AW'('h180), '0);
        end
        waitRequest("full A");
        ackHead(2);
        checkOutput("third accepted after ack", CHK_W'(reqReady), CHK_W'(1));
        collectResponse(0, 1'b0);
        reqValid = 1'b0;
        waitRequest("full B");
        ackHead(3);
        collectResponse(0, 1'b0);
        waitRequest("full C");
        ackHead(1);
        collectResponse(0, 1'b0);
        checkOutput("issue count", CHK_W'(issuedAddr.size()), CHK_W'(3));
        if (issuedAddr.size() == 3) begin
            checkOutput("issue order 0", CHK_W'(issuedAddr[0]), CHK_W'('h100));
            checkOutput("issue order 1", CHK_W'(issuedAddr[1]), CHK_W'('h140));
            checkOutput("issue order 2", CHK_W'(issuedAddr[2]), CHK_W'('h180));
        end

        // 4: response backpressure with a spurious ack while in RESP
        $display("[TB] backpressure");
        applyStimulus(1'b0, AW'('h200), '0, WW'('h40));
        applyStimulus(1'b0, AW'('h240), '0, WW'('h50));
        waitRequest("bp first");
        ackHead(3);
        collectResponse(5, 1'b1);
        waitRequest("bp second");
        ackHead(2);
        collectResponse(0, 1'b0);
        checkOutput("bp idle busy", CHK_W'(busy), CHK_W'(0));

        // 5: reset during WAIT abandons the transaction
        $display("[TB] reset mid-wait");
        applyStimulus(1'b0, AW'('h300), '0, WW'('h60));
        waitRequest("rst");
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst req_ready", CHK_W'(reqReady), CHK_W'(0));
        checkOutput("rst busy", CHK_W'(busy), CHK_W'(0));
        checkOutput("rst dram_address", CHK_W'(dramAddress), CHK_W'(0));
        checkOutput("rst dram_we", CHK_W'(dramWe), CHK_W'(0));
        checkOutput("rst rsp_data", CHK_W'(packBlock(rspData)), CHK_W'(0));
        expQ.delete();
        tick();
        tick();
        reset = 1'b1;
        savedPulses = reqPulses;
        tick();
        dramAcknowledge = 1'b1;
        for (int i = 0; i < BW; i++) begin
            dramReadData[i] = WW'('hDEAD);
        end
        tick();
        dramAcknowledge = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checkOutput("late ack rsp_valid", CHK_W'(rspValid), CHK_W'(0));
            checkOutput("late ack wr_done", CHK_W'(wrDone), CHK_W'(0));
            checkOutput("late ack busy", CHK_W'(busy), CHK_W'(0));
            tick();
        end
        checkOutput("no pulse after reset", CHK_W'(reqPulses), CHK_W'(savedPulses));
        checkOutput("ready after reset", CHK_W'(reqReady), CHK_W'(1));

        // 6: controller never answers
        $display("[TB] no-ack");
        applyStimulus(1'b0, AW'('h400), '0, WW'('h70));
        waitRequest("noack");
        checkOutput("noack no error yet", CHK_W'(timeoutError), CHK_W'(0));
`ifdef DRAM_REQ_TIMEOUT_EN
        for (int n = 0; n < 8; n++) begin
            tick();
            checkOutput("timeout wait no pulse", CHK_W'(dramRequest), CHK_W'(0));
            checkOutput("timeout wait no error", CHK_W'(timeoutError), CHK_W'(0));
        end
        tick();
        checkOutput("reissue pulse", CHK_W'(dramRequest), CHK_W'(1));
        checkOutput("timeout_error set", CHK_W'(timeoutError), CHK_W'(1));
        checkOutput("head kept", CHK_W'(dramAddress), CHK_W'('h400));
        ackHead(2);
        collectResponse(0, 1'b0);
        checkOutput("timeout_error sticky", CHK_W'(timeoutError), CHK_W'(1));
`else
        for (int n = 0; n < 20; n++) begin
            tick();
            checkOutput("wait forever no pulse", CHK_W'(dramRequest), CHK_W'(0));
            checkOutput("timeout_error tied", CHK_W'(timeoutError), CHK_W'(0));
        end
        ackHead(1);
        collectResponse(0, 1'b0);
`endif
        checkOutput("final busy", CHK_W'(busy), CHK_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
